sqrt_ctrl: RTL and testbench

SQRT_CTRL -- requirements
Module: sqrt_ctrl

---
 rtl/sqrt_ctrl.sv | 153 +++++++++++++++
 tb/tb_sqrt_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_ctrl.sv
// sqrt_ctrl: sequencing controller for an fp16 square-root datapath.
// Accepts one operand at a time, lets an external load stage split it into
// fields, resolves special operands directly and otherwise runs the
// iterative core for ITERS+1 cycles before presenting the result.
`timescale 1ns/1ps

module sqrt_ctrl #(
    parameter int ITERS = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        load_enable,
    output logic [15:0] load_data,
    input  logic        load_valid,
    input  logic        load_sign,
    input  logic [4:0]  load_exp,
    input  logic [9:0]  load_mant,
    output logic        iter_start,
    output logic        iter_step,
    output logic [3:0]  iter_idx,
    input  logic [15:0] core_result,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_invalid,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        DONE
    } state_t;

    localparam logic [3:0]  LAST_IDX = 4'(ITERS);
    localparam logic [15:0] QNAN     = 16'h7E00;
    localparam logic [15:0] POS_INF  = 16'h7C00;

    state_t      state;
    state_t      state_next;
    logic        result_load;
    logic [15:0] result_value;
    logic        result_invalid;
    logic        accept;

    // State register; reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, operand classification and decoded control outputs.
    always_comb begin
        state_next     = state;
        result_load    = 1'b0;
        result_value   = 16'h0000;
        result_invalid = 1'b0;
        in_ready       = (state == IDLE);
        load_enable    = (state != IDLE);
        busy           = (state != IDLE);
        out_valid      = (state == DONE);
        iter_start     = (state == ITER) && (iter_idx == 4'd0);
        iter_step      = (state == ITER) && (iter_idx != LAST_IDX);
        accept         = (state == IDLE) && in_valid;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    if (load_exp == 5'h1F && load_mant != 10'd0) begin
                        state_next     = DONE;
                        result_load    = 1'b1;
                        result_value   = QNAN;
                        result_invalid = 1'b1;
                    end else if (load_exp == 5'h00 && load_mant == 10'd0) begin
                        state_next     = DONE;
                        result_load    = 1'b1;
                        result_value   = {load_sign, 15'h0000};
                    end else if (load_sign) begin
                        state_next     = DONE;
                        result_load    = 1'b1;
                        result_value   = QNAN;
                        result_invalid = 1'b1;
                    end else if (load_exp == 5'h1F) begin
                        state_next     = DONE;
                        result_load    = 1'b1;
                        result_value   = POS_INF;
                    end else begin
                        state_next     = ITER;
                    end
                end
            end
            ITER: begin
                if (iter_idx == LAST_IDX) begin
                    state_next   = DONE;
                    result_load  = 1'b1;
                    result_value = core_result;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand register, only overwritten when a new operand is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_data <= 16'h0000;
        end else if (accept) begin
            load_data <= in_data;
        end
    end

    // Result registers, held stable through DONE until the consumer accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= 16'h0000;
            out_invalid <= 1'b0;
        end else if (result_load) begin
            out_data    <= result_value;
            out_invalid <= result_invalid;
        end
    end

    // Iteration index counts only while staying in ITER, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_idx <= 4'd0;
        end else if (state == ITER && state_next == ITER) begin
            iter_idx <= iter_idx + 4'd1;
        end else begin
            iter_idx <= 4'd0;
        end
    end

endmodule

// File: tb/tb_sqrt_ctrl.sv
// tb_sqrt_ctrl: self-checking bench for sqrt_ctrl with a load-stage model,
// a step-counting core model and a timeline-based reference model.
`timescale 1ns/1ps

module tb_sqrt_ctrl;

    localparam int ITERS = 11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_ready;
    logic        load_enable;
    logic [15:0] load_data;
    logic        load_valid;
    logic        load_sign;
    logic [4:0]  load_exp;
    logic [9:0]  load_mant;
    logic        iter_start;
    logic        iter_step;
    logic [3:0]  iter_idx;
    logic [15:0] core_result;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_invalid;
    logic        out_ready = 1'b0;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;
    int step_cnt = 0;
    int dut_results = 0;
    int ops_done = 0;

    // Reference model: an operation is a timeline measured in edges since accept.
    bit          m_active = 1'b0;
    bit          m_special = 1'b0;
    int          m_rel = 0;
    int          m_done_at = 0;
    logic [15:0] m_op = 16'h0000;
    logic [15:0] m_res = 16'h0000;
    logic        m_inv = 1'b0;

    int core_cnt;
    logic load_en_q;

    sqrt_ctrl #(.ITERS(ITERS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .load_enable(load_enable), .load_data(load_data),
        .load_valid(load_valid), .load_sign(load_sign),
        .load_exp(load_exp), .load_mant(load_mant),
        .iter_start(iter_start), .iter_step(iter_step), .iter_idx(iter_idx),
        .core_result(core_result),
        .out_valid(out_valid), .out_data(out_data), .out_invalid(out_invalid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int edge_no();
        return int'(($time - 5) / 10);
    endfunction

    function automatic logic [15:0] core_fn(input logic [15:0] x);
        return x - 16'h0400;
    endfunction

    function automatic void classify(input logic [15:0] op, output bit special,
                                     output logic [15:0] res, output logic inv);
        logic       s;
        logic [4:0] e;
        logic [9:0] m;
        s = op[15];
        e = op[14:10];
        m = op[9:0];
        special = 1'b1;
        inv = 1'b0;
        if (e == 5'd31 && m != 10'd0) begin
            res = 16'h7E00;
            inv = 1'b1;
        end else if (e == 5'd0 && m == 10'd0) begin
            res = {s, 15'h0000};
        end else if (s) begin
            res = 16'h7E00;
            inv = 1'b1;
        end else if (e == 5'd31) begin
            res = 16'h7C00;
        end else begin
            special = 1'b0;
            res = core_fn(op);
        end
    endfunction

    function automatic logic [15:0] gen_op();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom % 8)
            0: return {1'b0, 5'd31, r[9:0]};
            1: return {r[15], 15'h0000};
            2: return {1'b1, r[14:0]};
            3: return {1'b0, 5'd0, (r[9:0] == 10'd0) ? 10'd1 : r[9:0]};
            default: return {1'b0, 5'(1 + ($urandom % 30)), r[9:0]};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Load stage: on each rising edge of load_enable, split the operand and pulse valid.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_en_q  <= 1'b0;
            load_valid <= 1'b0;
            load_sign  <= 1'b0;
            load_exp   <= 5'd0;
            load_mant  <= 10'd0;
        end else begin
            load_en_q  <= load_enable;
            load_valid <= load_enable && !load_en_q;
            load_sign  <= load_data[15];
            load_exp   <= load_data[14:10];
            load_mant  <= load_data[9:0];
        end
    end

    // Core: result is only meaningful once ITERS steps have been counted.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_cnt <= 0;
        end else if (iter_start) begin
            core_cnt <= 1;
        end else if (iter_step) begin
            core_cnt <= core_cnt + 1;
        end
    end
    assign core_result = (core_cnt == ITERS) ? core_fn(load_data) : 16'hDEAD;

    // Reference model update on each edge, plus DUT handshake counting.
    always @(posedge clk or negedge rst_n) begin
        bit was_active;
        bit sp;
        if (!rst_n) begin
            m_active = 1'b0;
            m_rel    = 0;
            m_op     = 16'h0000;
        end else begin
            if (out_valid && out_ready) dut_results++;
            was_active = m_active;
            if (m_active) begin
                if (m_rel >= m_done_at && out_ready) m_active = 1'b0;
                else m_rel++;
            end
            if (!was_active && in_valid) begin
                m_active = 1'b1;
                m_rel    = 0;
                m_op     = in_data;
                classify(in_data, sp, m_res, m_inv);
                m_special = sp;
                m_done_at = sp ? 2 : ITERS + 3;
            end
        end
    end

    // Compare every output against the model once per cycle, away from the edge.
    always @(negedge clk) begin
        bit in_iter;
        bit ov;
        if (!rst_n) begin
            checkOutput("rst_in_ready", 16'(in_ready), 16'd1);
            checkOutput("rst_busy", 16'(busy), 16'd0);
            checkOutput("rst_load_enable", 16'(load_enable), 16'd0);
            checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
            checkOutput("rst_iter_idx", 16'(iter_idx), 16'd0);
            checkOutput("rst_load_data", load_data, 16'h0000);
            checkOutput("rst_out_data", out_data, 16'h0000);
            checkOutput("rst_out_invalid", 16'(out_invalid), 16'd0);
        end else begin
            ov = m_active && m_rel >= m_done_at;
            in_iter = m_active && !m_special && m_rel >= 2 && m_rel <= ITERS + 2;
            checkOutput("in_ready", 16'(in_ready), 16'(!m_active));
            checkOutput("busy", 16'(busy), 16'(m_active));
            checkOutput("load_enable", 16'(load_enable), 16'(m_active));
            checkOutput("load_data", load_data, m_op);
            checkOutput("out_valid", 16'(out_valid), 16'(ov));
            checkOutput("iter_idx", 16'(iter_idx), in_iter ? 16'(m_rel - 2) : 16'd0);
            checkOutput("iter_start", 16'(iter_start), 16'(in_iter && m_rel == 2));
            checkOutput("iter_step", 16'(iter_step), 16'(in_iter && m_rel <= ITERS + 1));
            if (ov) begin
                checkOutput("out_data", out_data, m_res);
                checkOutput("out_invalid", 16'(out_invalid), 16'(m_inv));
            end
            if (iter_start) start_cnt++;
            if (iter_step) step_cnt++;
        end
    end

    // Drive one operand through, with noise while busy and optional backpressure/chaining.
    task automatic applyStimulus(input logic [15:0] op, input int hold, input bit chain,
                                 input logic [15:0] nxt, output int lat, output logic [15:0] data,
                                 output logic inv, output int acc_edge, output int hs_edge,
                                 output int starts, output int steps);
        bit acc;
        bit got;
        bit r;
        int s0;
        int t0;
        acc = 1'b0;
        got = 1'b0;
        lat = -1;
        data = 16'hxxxx;
        inv = 1'bx;
        acc_edge = -1;
        hs_edge = -1;
        in_valid = 1'b1;
        in_data = op;
        s0 = start_cnt;
        t0 = step_cnt;
        for (int i = 0; i < 40 && !acc; i++) begin
            r = in_ready;
            @(posedge clk);
            if (r) begin
                acc = 1'b1;
                acc_edge = edge_no();
            end
            #1;
        end
        if (!acc) begin
            checkOutput("accept_timeout", 16'd0, 16'd1);
            in_valid = 1'b0;
            starts = 0;
            steps = 0;
            return;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
            else begin
                in_valid = 1'($urandom % 2);
                in_data = 16'($urandom);
                out_ready = 1'($urandom % 2);
            end
        end
        if (!got) begin
            checkOutput("done_timeout", 16'd0, 16'd1);
            in_valid = 1'b0;
            out_ready = 1'b0;
            starts = 0;
            steps = 0;
            return;
        end
        lat = edge_no() - acc_edge;
        data = out_data;
        inv = out_invalid;
        in_valid = 1'b1;
        in_data = 16'($urandom);
        out_ready = (hold == 0);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        @(posedge clk);
        hs_edge = edge_no();
        #1;
        out_ready = 1'b0;
        in_valid = chain;
        in_data = chain ? nxt : 16'h0000;
        ops_done++;
        starts = start_cnt - s0;
        steps = step_cnt - t0;
    endtask

    logic [15:0] spec_ops [4] = '{16'hBC00, 16'h8000, 16'h7C00, 16'h7D00};
    logic [15:0] spec_res [4] = '{16'h7E00, 16'h8000, 16'h7C00, 16'h7E00};
    logic        spec_inv [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int lat, acc_e, hs_e, st, sp, prev_hs;
        logic [15:0] d, cur, nxt, er;
        logic inv, ei;
        bit chain, prev_chain, esp;

        rst_n = 1'b0;
        #1;
        checkOutput("reset_in_ready", 16'(in_ready), 16'd1);
        checkOutput("reset_out_valid", 16'(out_valid), 16'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Normal operand with hand-computed expectations.
        applyStimulus(16'h4400, 0, 1'b0, 16'h0000, lat, d, inv, acc_e, hs_e, st, sp);
        checkOutput("norm_latency", 16'(lat), 16'd14);
        checkOutput("norm_data", d, 16'h4000);
        checkOutput("norm_invalid", 16'(inv), 16'd0);
        checkOutput("norm_starts", 16'(st), 16'd1);
        checkOutput("norm_steps", 16'(sp), 16'd11);

        // Special operands resolve at E2 without touching the core.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(spec_ops[i], 0, 1'b0, 16'h0000, lat, d, inv, acc_e, hs_e, st, sp);
            checkOutput("spec_latency", 16'(lat), 16'd2);
            checkOutput("spec_data", d, spec_res[i]);
            checkOutput("spec_invalid", 16'(inv), 16'(spec_inv[i]));
            checkOutput("spec_starts", 16'(st), 16'd0);
        end

        // Backpressure for five DONE cycles, then load_enable must drop.
        applyStimulus(16'h3E00, 5, 1'b0, 16'h0000, lat, d, inv, acc_e, hs_e, st, sp);
        checkOutput("bp_data", d, 16'h3A00);
        checkOutput("bp_idle_load_enable", 16'(load_enable), 16'd0);

        // Back-to-back with in_valid held high.
        applyStimulus(16'h4800, 0, 1'b1, 16'h7C00, lat, d, inv, acc_e, hs_e, st, sp);
        prev_hs = hs_e;
        applyStimulus(16'h7C00, 0, 1'b0, 16'h0000, lat, d, inv, acc_e, hs_e, st, sp);
        checkOutput("b2b_accept_edge", 16'(acc_e), 16'(prev_hs + 1));
        checkOutput("b2b_data", d, 16'h7C00);

        // Reset in the middle of iteration abandons the operation.
        in_valid = 1'b1;
        in_data = 16'h4400;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 40 && iter_idx != 4'd5; i++) @(negedge clk);
        checkOutput("mid_reset_reach_idx5", 16'(iter_idx), 16'd5);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_load_enable", 16'(load_enable), 16'd0);
        checkOutput("mid_reset_iter_step", 16'(iter_step), 16'd0);
        checkOutput("mid_reset_out_valid", 16'(out_valid), 16'd0);
        checkOutput("mid_reset_iter_idx", 16'(iter_idx), 16'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(16'h3C00, 0, 1'b0, 16'h0000, lat, d, inv, acc_e, hs_e, st, sp);
        checkOutput("post_reset_latency", 16'(lat), 16'd14);
        checkOutput("post_reset_data", d, 16'h3800);

        // Randomized operands, holds and chaining against the model.
        prev_chain = 1'b0;
        prev_hs = 0;
        nxt = gen_op();
        for (int i = 0; i < 40; i++) begin
            cur = nxt;
            nxt = gen_op();
            chain = (i != 39) && ($urandom % 2 == 1);
            applyStimulus(cur, int'($urandom % 4), chain, nxt, lat, d, inv, acc_e, hs_e, st, sp);
            classify(cur, esp, er, ei);
            checkOutput("rand_data", d, er);
            checkOutput("rand_invalid", 16'(inv), 16'(ei));
            checkOutput("rand_latency", 16'(lat), esp ? 16'd2 : 16'(ITERS + 3));
            if (prev_chain) checkOutput("rand_b2b_edge", 16'(acc_e), 16'(prev_hs + 1));
            prev_chain = chain;
            prev_hs = hs_e;
        end

        repeat (3) @(negedge clk);
        checkOutput("result_count", 16'(dut_results), 16'(ops_done));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
